// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response port and a word-wide data memory.
// Handles byte/halfword/word accesses, sign extension and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state, state_next;
  logic        we_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;

  logic        accept, req_err;
  logic [31:0] lane_data, load_val, lane_mask, wdata_shift, store_word;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Errors are resolved at acceptance so a bad request never touches memory.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = req_addr[0];
      SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
  end

  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                             state_next = RESP;
          else if (req_we && req_size == SIZE_WORD) state_next = WRITE;
          else                                      state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == READ) word_q <= mem_rd;
    end
  end

  // Aligned halfwords have addr[0]=0, so a byte-granular shift serves both sizes.
  assign lane_data = word_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = 32'h0;
    case (size_q)
      SIZE_BYTE: load_val = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      SIZE_HALF: load_val = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      SIZE_WORD: load_val = word_q;
      default:   load_val = 32'h0;
    endcase
  end

  always_comb begin
    lane_mask = 32'h0;
    case (size_q)
      SIZE_BYTE: lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      SIZE_HALF: lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      default:   lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign wdata_shift = wdata_q << {addr_q[1:0], 3'b000};
  assign store_word  = (size_q == SIZE_WORD) ? wdata_q
                                             : ((word_q & ~lane_mask) | (wdata_shift & lane_mask));

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP && !we_q && !err_q) ? load_val : 32'h0;

  assign mem_we   = (state == WRITE);
  assign mem_addr = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wd   = (state == WRITE) ? store_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// compared against an arithmetic reference model of memory and load/store semantics.
module tb_load_store_unit;

  localparam int MEM_WORDS = 64;
  localparam int IDX_W     = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] dut_mem  [MEM_WORDS];
  logic [31:0] seed_mem [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        load_mem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Attached data memory: combinational read, word write on the clock edge.
  always_comb begin
    mem_rd = 32'hDEAD_BEEF;
    if (mem_addr[31:2] < 30'(MEM_WORDS)) mem_rd = dut_mem[mem_addr[2 +: IDX_W]];
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < MEM_WORDS; i++) dut_mem[i] <= seed_mem[i];
    end else if (mem_we && mem_addr[31:2] < 30'(MEM_WORDS)) begin
      dut_mem[mem_addr[2 +: IDX_W]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour from access size, offset and memory contents.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata,
                                output int lat, output logic [31:0] new_word);
    longint unsigned idx, off, nbytes, w, val, mask, lim;
    idx = addr / 4;
    off = addr % 4;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    err = (size == 3) || (off % nbytes != 0) || (idx >= MEM_WORDS);
    rdata = 0;
    new_word = 0;
    if (err) begin
      lat = 1;
      return;
    end
    w = ref_mem[idx];
    lim = longint'(1) << (8 * nbytes);
    if (!we) begin
      lat = 2;
      val = (w >> (8 * off)) % lim;
      if (sgn && nbytes < 4 && val >= lim / 2) val = val + 64'h1_0000_0000 - lim;
      rdata = val[31:0];
    end else begin
      lat = (nbytes == 4) ? 2 : 3;
      mask = (lim - 1) << (8 * off);
      val = (w & ~mask) | ((longint'(wdata) << (8 * off)) & mask);
      new_word = val[31:0];
    end
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic        e_err;
    logic [31:0] e_rdata, e_word, got_wd, got_ma, held;
    int          e_lat, lat, we_cnt;
    bit          done;
    model(we, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_word);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Junk request held while busy must be ignored.
    req_we = 1'b1; req_size = 2'($urandom); req_addr = $urandom_range(0, 255); req_wdata = $urandom;
    lat = 1; we_cnt = 0; got_wd = 0; got_ma = 0; done = 0;
    while (!done && lat <= 8) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        got_wd = mem_wd;
        got_ma = mem_addr;
      end
      if (resp_valid) done = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check("resp_timeout", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_rdata", resp_rdata, e_rdata);
    check("mem_we_pulses", 32'(we_cnt), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) begin
      check("mem_wd", got_wd, e_word);
      check("mem_addr", got_ma, {addr[31:2], 2'b00});
    end
    check("idle_mem_bus", {mem_addr[30:0] | mem_wd[30:0], mem_we}, 32'd0);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {resp_valid, req_ready}, 32'b10);
      check("hold_rdata", resp_rdata, held);
      check("hold_err", 32'(resp_err), 32'(e_err));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    if (we && !e_err) ref_mem[addr[31:2]] = e_word;
    @(negedge clk);
    check("back_to_idle", {resp_valid, req_ready}, 32'b01);
  endtask

  task automatic reset_mid_store(input logic [31:0] addr);
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = addr; req_wdata = 32'hA5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("in_read_bus", mem_addr, {addr[31:2], 2'b00});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (mem_we || resp_valid) seen++;
      @(negedge clk);
    end
    check("rst_mid_quiet", 32'(seen), 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_mem = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end
    seed_mem[4] = 32'h8899_AABB;
    ref_mem[4]  = 32'h8899_AABB;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; load_mem = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);

    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1);
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h5A, 0);
    check("rmw_word4", ref_mem[4], 32'h8899_5ABB);
    run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0);
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, 0);
    run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    run_req(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFE_F00D, 2);
    run_req(1'b1, 2'b01, 1'b1, 32'h16, 32'hFFFF_8001, 0);
    reset_mid_store(32'h21);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(MEM_WORDS * 4, MEM_WORDS * 4 + 64)
                                      : $urandom_range(0, MEM_WORDS * 4 - 1);
      run_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("mem[%0d]", i), dut_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
